cursor_ctrl: RTL and testbench

Frame-synchronous controller for the cursor sprite overlay. It sits between the CPU video slot and the cursor overlay's slot port, which it owns exclusively. It accumulates pointer movement deltas with screen-edge clamping and commits position and visibility to the overlay only at frame boundaries, so the cursor never tears. It also auto-hides the cursor after a configurable idle period and passes CPU sprite-RAM writes through.

---
 rtl/cursor_pkg.sv | 34 +++
 rtl/cursor_clamp.sv | 37 +++
 rtl/cursor_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_cursor_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cursor_pkg
// Description : Shared constants for the cursor overlay controller: commit
//               FSM state encoding, overlay register offsets and the address
//               bit that separates sprite RAM from the register space.
// Revision    : 1.0 - initial release
// ============================================================================
package cursor_pkg;

    typedef logic [1:0] state_t;

    // Commit sequencer states
    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_WR_X   = 2'd1;
    localparam state_t c_ST_WR_Y   = 2'd2;
    localparam state_t c_ST_WR_BYP = 2'd3;

    // Overlay / CPU register offsets (addr[1:0] inside the register space)
    localparam logic [1:0] REG_BYPASS = 2'b00;
    localparam logic [1:0] REG_X0     = 2'b01;
    localparam logic [1:0] REG_Y0     = 2'b10;
    localparam logic [1:0] REG_AUTO   = 2'b11;

    // addr[13] = 1 selects registers, 0 selects sprite RAM
    localparam int REG_SPACE_BIT = 13;

    // Full overlay address of a register offset
    function automatic logic [13:0] reg_addr(input logic [1:0] off);
        return {1'b1, 11'd0, off};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cursor_clamp.sv
`default_nettype none
// ============================================================================
// Module      : cursor_clamp
// Description : Combinational signed 12-bit add of a base coordinate and a
//               delta, clamped to [0, LIMIT].
// Ports       : i_base  - current (or directly written) coordinate, unsigned
//               i_delta - signed delta (0 for direct writes)
//               o_pos   - clamped result
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_clamp #(
    parameter int LIMIT = 608
) (
    input  logic        [10:0] i_base,
    input  logic signed [11:0] i_delta,
    output logic        [10:0] o_pos
);

    localparam logic signed [11:0] c_LIMIT = 12'(LIMIT);

    logic signed [11:0] w_sum;

    // Base is at most 2047 only when delta is zero, so 12 bits never overflow
    assign w_sum = $signed({1'b0, i_base}) + i_delta;

    always_comb begin
        if (w_sum < 12'sd0) begin
            o_pos = 11'd0;
        end else if (w_sum > c_LIMIT) begin
            o_pos = c_LIMIT[10:0];
        end else begin
            o_pos = w_sum[10:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cursor_ctrl
// Description : Frame-synchronous cursor sprite controller. Accumulates
//               pointer deltas with edge clamping, auto-hides after an idle
//               period, passes CPU sprite-RAM writes through, and commits
//               x0/y0/bypass to the overlay only after a frame tick.
// Ports       : clk, reset (async, active-high)
//               i_frame_tick          - start-of-vblank pulse
//               i_cpu_*, o_cpu_ready  - CPU slot (writes only)
//               i_pos_*, o_pos_ready  - movement delta stream
//               o_ovl_*               - registered overlay slot master
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int CUR_W       = 32,
    parameter int CUR_H       = 32,
    parameter int IDLE_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_frame_tick,
    input  logic        i_cpu_cs,
    input  logic        i_cpu_write,
    input  logic [13:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wr_data,
    output logic        o_cpu_ready,
    input  logic        i_pos_valid,
    output logic        o_pos_ready,
    input  logic [8:0]  i_pos_dx,
    input  logic [8:0]  i_pos_dy,
    output logic        o_ovl_cs,
    output logic        o_ovl_write,
    output logic [13:0] o_ovl_addr,
    output logic [31:0] o_ovl_wr_data
);
    import cursor_pkg::*;

    localparam logic [7:0] c_IDLE_MAX = 8'(IDLE_FRAMES);

    state_t      r_state;
    logic [10:0] r_cur_x, r_cur_y, r_snap_y;
    logic        r_sw_hide, r_auto_en, r_snap_hide;
    logic [7:0]  r_idle_cnt;
    logic        r_pending, r_dirty;

    logic        w_hide_eff, w_commit_req, w_ready;
    logic        w_cpu_acc, w_cpu_reg, w_cpu_ram, w_cpu_x, w_cpu_y, w_cpu_pos;
    logic        w_pos_acc, w_moved, w_change, w_pend_clr;
    logic        w_sw_hide_nxt, w_auto_en_nxt, w_hide_nxt;
    logic [7:0]  w_idle_nxt;
    logic signed [11:0] w_dx_ext, w_dy_ext, w_x_delta, w_y_delta;
    logic [10:0] w_x_base, w_y_base, w_x_new, w_y_new;

    assign w_hide_eff   = r_sw_hide | (r_auto_en & (r_idle_cnt == c_IDLE_MAX));
    assign w_commit_req = r_pending & r_dirty;
    assign w_ready      = (r_state == c_ST_IDLE) & ~w_commit_req;

    assign w_cpu_acc = i_cpu_cs & i_cpu_write & w_ready;
    assign w_cpu_reg = w_cpu_acc & i_cpu_addr[REG_SPACE_BIT];
    assign w_cpu_ram = w_cpu_acc & ~i_cpu_addr[REG_SPACE_BIT];
    assign w_cpu_x   = w_cpu_reg & (i_cpu_addr[1:0] == REG_X0);
    assign w_cpu_y   = w_cpu_reg & (i_cpu_addr[1:0] == REG_Y0);
    assign w_cpu_pos = w_cpu_x | w_cpu_y;

    // A CPU position write takes priority over a delta in the same cycle
    assign o_cpu_ready = w_ready;
    assign o_pos_ready = w_ready & ~w_cpu_pos;
    assign w_pos_acc   = i_pos_valid & o_pos_ready;
    assign w_moved     = w_pos_acc & ((|i_pos_dx) | (|i_pos_dy));

    assign w_dx_ext  = {{3{i_pos_dx[8]}}, i_pos_dx};
    assign w_dy_ext  = {{3{i_pos_dy[8]}}, i_pos_dy};
    // Direct writes reuse the clamp with a zero delta
    assign w_x_base  = w_cpu_x ? i_cpu_wr_data[10:0] : r_cur_x;
    assign w_y_base  = w_cpu_y ? i_cpu_wr_data[10:0] : r_cur_y;
    assign w_x_delta = w_cpu_x ? 12'sd0 : w_dx_ext;
    assign w_y_delta = w_cpu_y ? 12'sd0 : w_dy_ext;

    cursor_clamp #(.LIMIT(H_ACTIVE - CUR_W)) u_clamp_x (
        .i_base (w_x_base),
        .i_delta(w_x_delta),
        .o_pos  (w_x_new)
    );

    cursor_clamp #(.LIMIT(V_ACTIVE - CUR_H)) u_clamp_y (
        .i_base (w_y_base),
        .i_delta(w_y_delta),
        .o_pos  (w_y_new)
    );

    // Next values of the hide inputs, so a hide change is flagged dirty in
    // the same edge that creates it (the auto-hide tick also sets pending).
    always_comb begin
        w_sw_hide_nxt = r_sw_hide;
        w_auto_en_nxt = r_auto_en;
        w_idle_nxt    = r_idle_cnt;
        if (w_cpu_reg && (i_cpu_addr[1:0] == REG_BYPASS)) begin
            w_sw_hide_nxt = i_cpu_wr_data[0];
        end
        if (w_cpu_reg && (i_cpu_addr[1:0] == REG_AUTO)) begin
            w_auto_en_nxt = i_cpu_wr_data[0];
        end
        if (w_cpu_pos || w_moved) begin
            w_idle_nxt = 8'd0;
        end else if (i_frame_tick && (r_idle_cnt != c_IDLE_MAX)) begin
            w_idle_nxt = r_idle_cnt + 8'd1;
        end
        w_hide_nxt = w_sw_hide_nxt | (w_auto_en_nxt & (w_idle_nxt == c_IDLE_MAX));
    end

    assign w_change   = w_cpu_pos | w_pos_acc | (w_hide_nxt != w_hide_eff);
    assign w_pend_clr = ((r_state == c_ST_IDLE) & r_pending & ~r_dirty) |
                        (r_state == c_ST_WR_BYP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_cur_x       <= 11'd0;
            r_cur_y       <= 11'd0;
            r_snap_y      <= 11'd0;
            r_snap_hide   <= 1'b0;
            r_sw_hide     <= 1'b0;
            r_auto_en     <= 1'b0;
            r_idle_cnt    <= 8'd0;
            r_pending     <= 1'b0;
            r_dirty       <= 1'b1;
            o_ovl_cs      <= 1'b0;
            o_ovl_write   <= 1'b0;
            o_ovl_addr    <= 14'd0;
            o_ovl_wr_data <= 32'd0;
        end else begin
            r_sw_hide  <= w_sw_hide_nxt;
            r_auto_en  <= w_auto_en_nxt;
            r_idle_cnt <= w_idle_nxt;
            if (w_cpu_x || w_pos_acc) begin
                r_cur_x <= w_x_new;
            end
            if (w_cpu_y || w_pos_acc) begin
                r_cur_y <= w_y_new;
            end
            // A tick is never lost: set has priority over clear
            r_pending <= i_frame_tick | (r_pending & ~w_pend_clr);
            r_dirty   <= r_dirty | w_change;

            o_ovl_cs      <= 1'b0;
            o_ovl_write   <= 1'b0;
            o_ovl_addr    <= 14'd0;
            o_ovl_wr_data <= 32'd0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_cpu_ram) begin
                        o_ovl_cs      <= 1'b1;
                        o_ovl_write   <= 1'b1;
                        o_ovl_addr    <= i_cpu_addr;
                        o_ovl_wr_data <= i_cpu_wr_data;
                    end else if (w_commit_req) begin
                        // dirty now means "changed since this snapshot", so
                        // anything arriving during the commit survives it
                        r_state       <= c_ST_WR_X;
                        r_snap_y      <= r_cur_y;
                        r_snap_hide   <= w_hide_eff;
                        r_dirty       <= w_change;
                        o_ovl_cs      <= 1'b1;
                        o_ovl_write   <= 1'b1;
                        o_ovl_addr    <= reg_addr(REG_X0);
                        o_ovl_wr_data <= {21'd0, r_cur_x};
                    end
                end
                c_ST_WR_X: begin
                    r_state       <= c_ST_WR_Y;
                    o_ovl_cs      <= 1'b1;
                    o_ovl_write   <= 1'b1;
                    o_ovl_addr    <= reg_addr(REG_Y0);
                    o_ovl_wr_data <= {21'd0, r_snap_y};
                end
                c_ST_WR_Y: begin
                    r_state       <= c_ST_WR_BYP;
                    o_ovl_cs      <= 1'b1;
                    o_ovl_write   <= 1'b1;
                    o_ovl_addr    <= reg_addr(REG_BYPASS);
                    o_ovl_wr_data <= {31'd0, r_snap_hide};
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cursor_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
module tb_cursor_ctrl;

    localparam int XMAX = 640 - 32;
    localparam int YMAX = 480 - 32;
    localparam int IDLE = 120;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        cpu_cs, cpu_write;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic        cpu_ready;
    logic        pos_valid, pos_ready;
    logic [8:0]  pos_dx, pos_dy;
    logic        ovl_cs, ovl_write;
    logic [13:0] ovl_addr;
    logic [31:0] ovl_wr_data;

    always #5 clk = ~clk;

    cursor_ctrl #(
        .H_ACTIVE(640), .V_ACTIVE(480), .CUR_W(32), .CUR_H(32), .IDLE_FRAMES(IDLE)
    ) dut (
        .clk(clk), .reset(reset), .i_frame_tick(frame_tick),
        .i_cpu_cs(cpu_cs), .i_cpu_write(cpu_write), .i_cpu_addr(cpu_addr),
        .i_cpu_wr_data(cpu_wr_data), .o_cpu_ready(cpu_ready),
        .i_pos_valid(pos_valid), .o_pos_ready(pos_ready),
        .i_pos_dx(pos_dx), .i_pos_dy(pos_dy),
        .o_ovl_cs(ovl_cs), .o_ovl_write(ovl_write),
        .o_ovl_addr(ovl_addr), .o_ovl_wr_data(ovl_wr_data)
    );

    int checks = 0;
    int failures = 0;
    logic [45:0] exp_q[$];

    // Reference model: cursor state as the CPU/pointer would see it
    int m_x, m_y, m_idle;
    bit m_sw, m_auto, m_dirty;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int mx);
        return (v < 0) ? 0 : ((v > mx) ? mx : v);
    endfunction

    function automatic bit m_hide();
        return m_sw | (m_auto && (m_idle == IDLE));
    endfunction

    function automatic logic [45:0] rec(input logic [1:0] off, input int val);
        return {1'b1, 11'd0, off, 32'(val)};
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_idle = 0; m_sw = 0; m_auto = 0; m_dirty = 1;
    endtask

    // Frame tick as seen by the model; queues the commit if anything changed
    task automatic model_tick(output bit commit);
        bit h0;
        h0 = m_hide();
        m_idle = (m_idle < IDLE) ? m_idle + 1 : IDLE;
        if (m_hide() != h0) m_dirty = 1;
        commit = m_dirty;
        if (commit) begin
            exp_q.push_back(rec(2'b01, m_x));
            exp_q.push_back(rec(2'b10, m_y));
            exp_q.push_back(rec(2'b00, int'(m_hide())));
            m_dirty = 0;
        end
    endtask

    task automatic model_cpu(input logic [13:0] a, input logic [31:0] d);
        bit h0;
        h0 = m_hide();
        if (!a[13]) begin
            exp_q.push_back({a, d});
        end else begin
            case (a[1:0])
                2'b00: m_sw = d[0];
                2'b01: begin m_x = clampi(int'(d[10:0]), XMAX); m_dirty = 1; m_idle = 0; end
                2'b10: begin m_y = clampi(int'(d[10:0]), YMAX); m_dirty = 1; m_idle = 0; end
                default: m_auto = d[0];
            endcase
        end
        if (m_hide() != h0) m_dirty = 1;
    endtask

    task automatic model_delta(input int dx, input int dy);
        bit h0;
        h0 = m_hide();
        m_x = clampi(m_x + dx, XMAX);
        m_y = clampi(m_y + dy, YMAX);
        m_dirty = 1;
        if (dx != 0 || dy != 0) m_idle = 0;
        if (m_hide() != h0) m_dirty = 1;
    endtask

    // Scoreboard monitor: every overlay write must match the next expectation
    always @(negedge clk) begin
        if (!reset && ovl_cs) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ovl_unexpected actual=%0h_%0h required=none", ovl_addr, ovl_wr_data);
            end else begin
                logic [45:0] e;
                e = exp_q.pop_front();
                if ({ovl_write, ovl_addr, ovl_wr_data} !== {1'b1, e}) begin
                    failures++;
                    $display("FAIL ovl_write actual=%0h_%0h_%0h required=1_%0h_%0h",
                             ovl_write, ovl_addr, ovl_wr_data, e[45:32], e[31:0]);
                end
            end
        end
    end

    task automatic cpu_wr(input logic [13:0] a, input logic [31:0] d);
        cpu_cs = 1; cpu_write = 1; cpu_addr = a; cpu_wr_data = d;
        #1 chk("cpu_ready", cpu_ready, 1);
        model_cpu(a, d);
        @(negedge clk);
        cpu_cs = 0; cpu_write = 0;
    endtask

    task automatic delta(input int dx, input int dy);
        pos_valid = 1; pos_dx = 9'(dx); pos_dy = 9'(dy);
        #1 chk("pos_ready", pos_ready, 1);
        model_delta(dx, dy);
        @(negedge clk);
        pos_valid = 0;
    endtask

    task automatic tick();
        bit commit;
        frame_tick = 1;
        model_tick(commit);
        @(negedge clk);
        frame_tick = 0;
        #1 chk("ready_after_tick", cpu_ready, !commit);
        chk("ovl_cs_after_tick", ovl_cs, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk("ovl_cs_commit", ovl_cs, commit);
            chk("ready_commit", cpu_ready, 0 || !commit);
        end
        @(negedge clk);
        #1 chk("ovl_cs_post", ovl_cs, 0);
        chk("ready_post", cpu_ready, 1);
    endtask

    // CPU x write and a delta in the same cycle: CPU wins, delta waits
    task automatic collide(input int xv, input int dx, input int dy);
        cpu_cs = 1; cpu_write = 1; cpu_addr = 14'h2001; cpu_wr_data = 32'(xv);
        pos_valid = 1; pos_dx = 9'(dx); pos_dy = 9'(dy);
        #1 chk("collide_pos_ready", pos_ready, 0);
        chk("collide_cpu_ready", cpu_ready, 1);
        model_cpu(14'h2001, 32'(xv));
        @(negedge clk);
        cpu_cs = 0; cpu_write = 0;
        #1 chk("collide_pos_ready_next", pos_ready, 1);
        model_delta(dx, dy);
        @(negedge clk);
        pos_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit commit;
        int low;
        reset = 1; frame_tick = 0; cpu_cs = 0; cpu_write = 0; cpu_addr = 0;
        cpu_wr_data = 0; pos_valid = 0; pos_dx = 0; pos_dy = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ovl_cs", ovl_cs, 0);
        chk("rst_ovl_addr", ovl_addr, 0);
        chk("rst_ovl_data", ovl_wr_data, 0);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_cpu_ready", cpu_ready, 1);
        chk("rst_pos_ready", pos_ready, 1);

        tick();                                   // first commit: 0,0,0

        delta(255, -5); delta(255, 0); delta(190, 0);
        tick();                                   // x clamps to 608

        cpu_wr(14'h0005, 32'hABC);                // RAM pass-through
        cpu_wr(14'h2001, 32'd100);
        #1 chk("reg_write_not_forwarded", ovl_cs, 0);
        tick();

        cpu_wr(14'h2003, 32'd1);                  // auto-hide enable
        for (int i = 0; i < 125; i++) tick();
        delta(1, 0);
        tick();

        collide(300, -20, 7);
        tick();

        // delta held across a commit
        delta(5, 5);
        frame_tick = 1;
        model_tick(commit);
        @(negedge clk); frame_tick = 0;
        @(negedge clk);
        pos_valid = 1; pos_dx = 9'd9; pos_dy = 9'd2;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (pos_ready) break;
            low++;
            @(negedge clk);
        end
        chk("pos_ready_low_cycles", low, 3);
        model_delta(9, 2);
        @(negedge clk); pos_valid = 0;
        tick();
        tick();                                   // nothing changed: no writes

        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                delta($urandom_range(0, 511) - 256, $urandom_range(0, 511) - 256);
            end else if (r == 3) begin
                cpu_wr({1'b0, 13'($urandom)}, $urandom);
            end else if (r <= 5) begin
                logic [1:0] off;
                off = 2'($urandom_range(0, 3));
                cpu_wr({1'b1, 11'($urandom), off},
                       (off == 2'b01 || off == 2'b10) ? 32'($urandom_range(0, 2047))
                                                      : 32'($urandom_range(0, 1)));
            end else if (r == 6) begin
                collide($urandom_range(0, 2047), $urandom_range(0, 511) - 256,
                        $urandom_range(0, 511) - 256);
            end else begin
                tick();
            end
        end

        // reset in the middle of a commit
        delta(3, 4);
        frame_tick = 1;
        model_tick(commit);
        @(negedge clk); frame_tick = 0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1;
        #1 chk("midreset_ovl_cs", ovl_cs, 0);
        chk("midreset_ovl_addr", ovl_addr, 0);
        chk("midreset_ovl_data", ovl_wr_data, 0);
        chk("midreset_pending_writes", exp_q.size(), 1);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("midreset_ready", cpu_ready, 1);
        tick();                                   // full recommit

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
